// File: rtl/spy_path_sampler.sv
// rtl/spy_path_sampler.sv - launch/capture controller for a spy delay chain, counts late edges.
// Optional macro SPY_SAMPLER_SYNC_EN adds a two-flop synchronizer and SYNC state after capture.
module spy_path_sampler #(
  parameter bit CHAIN_INVERTS = 1'b0,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [CNT_W-1:0] numSamples,
  output logic             launchOut,
  input  logic             pathResult,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sampleCount,
  output logic [CNT_W-1:0] errCount
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_CAPTURE,
`ifdef SPY_SAMPLER_SYNC_EN
    S_SYNC,
`endif
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_settle_cnt;
  logic             r_launch;
  logic             r_cap;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_samp;
  logic [CNT_W-1:0] r_err;

  state_t           w_state_nxt;
  logic [SW-1:0]    w_settle_nxt;
  logic             w_launch_nxt;
  logic             w_cap_nxt;
  logic [CNT_W-1:0] w_target_nxt;
  logic [CNT_W-1:0] w_samp_nxt;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_samp_inc;
  logic             w_cmp_val;

  assign w_samp_inc = r_samp + CNT_W'(1);

`ifdef SPY_SAMPLER_SYNC_EN
  logic r_sync1;
  logic r_sync2;
  logic r_sync_cnt;
  logic w_sync_cnt_nxt;

  // Free-running shift; COMPARE only looks at r_sync2 after two SYNC cycles.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync_cnt <= 1'b0;
    end else begin
      r_sync1    <= r_cap;
      r_sync2    <= r_sync1;
      r_sync_cnt <= w_sync_cnt_nxt;
    end
  end

  assign w_cmp_val = r_sync2;
`else
  assign w_cmp_val = r_cap;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_launch     <= 1'b0;
      r_cap        <= 1'b0;
      r_target     <= '0;
      r_samp       <= '0;
      r_err        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_launch     <= w_launch_nxt;
      r_cap        <= w_cap_nxt;
      r_target     <= w_target_nxt;
      r_samp       <= w_samp_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    w_launch_nxt = r_launch;
    w_cap_nxt    = r_cap;
    w_target_nxt = r_target;
    w_samp_nxt   = r_samp;
    w_err_nxt    = r_err;
`ifdef SPY_SAMPLER_SYNC_EN
    w_sync_cnt_nxt = r_sync_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_target_nxt = numSamples;
          w_samp_nxt   = '0;
          w_err_nxt    = '0;
          w_settle_nxt = SETTLE_LOAD;
          w_state_nxt  = (numSamples == '0) ? S_DONE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == '0) w_state_nxt = S_LAUNCH;
        else                    w_settle_nxt = r_settle_cnt - SW'(1);
      end
      S_LAUNCH: begin
        w_launch_nxt = ~r_launch;
        w_state_nxt  = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Sole sampling point of pathResult: one clk after the launch edge.
        w_cap_nxt = pathResult;
`ifdef SPY_SAMPLER_SYNC_EN
        w_sync_cnt_nxt = 1'b0;
        w_state_nxt    = S_SYNC;
`else
        w_state_nxt = S_COMPARE;
`endif
      end
`ifdef SPY_SAMPLER_SYNC_EN
      S_SYNC: begin
        w_sync_cnt_nxt = 1'b1;
        if (r_sync_cnt) w_state_nxt = S_COMPARE;
      end
`endif
      S_COMPARE: begin
        if (w_cmp_val != (r_launch ^ CHAIN_INVERTS)) w_err_nxt = r_err + CNT_W'(1);
        w_samp_nxt   = w_samp_inc;
        w_settle_nxt = SETTLE_LOAD;
        w_state_nxt  = (w_samp_inc == r_target) ? S_DONE : S_SETTLE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign launchOut   = r_launch;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign sampleCount = r_samp;
  assign errCount    = r_err;

endmodule

// File: tb/tb_spy_path_sampler.sv
// tb/tb_spy_path_sampler.sv - directed and randomized bench for spy_path_sampler with behavioural chains.
module tb_spy_path_sampler;

  localparam int CNT_W  = 16;
  localparam int SETTLE = 4;
`ifdef SPY_SAMPLER_SYNC_EN
  localparam int COST = SETTLE + 5;
`else
  localparam int COST = SETTLE + 3;
`endif

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] numSamples = '0;
  logic             launch0, launch1, busy0, busy1, done0, done1;
  logic [CNT_W-1:0] sc0, sc1, ec0, ec1;
  logic             path0 = 1'b0;
  logic             path1 = 1'b1;
  int               delay_ns = 1;
  int               total = 0;
  int               bad = 0;
  logic             lvl = 1'b0;

  always #5 clk = ~clk;

  // Behavioural chains: buffer for dut0, inverter for dut1, transport delay delay_ns.
  always @(launch0) path0 <= #(delay_ns) launch0;
  always @(launch1) path1 <= #(delay_ns) ~launch1;

  spy_path_sampler #(.CHAIN_INVERTS(1'b0), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) dut0 (
    .clk(clk), .rstN(rstN), .start(start), .numSamples(numSamples), .launchOut(launch0),
    .pathResult(path0), .busy(busy0), .done(done0), .sampleCount(sc0), .errCount(ec0)
  );

  spy_path_sampler #(.CHAIN_INVERTS(1'b1), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE)) dut1 (
    .clk(clk), .rstN(rstN), .start(start), .numSamples(numSamples), .launchOut(launch1),
    .pathResult(path1), .busy(busy1), .done(done1), .sampleCount(sc1), .errCount(ec1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_launch0"}, 32'(launch0), 32'(0));
    chk({tag, "_launch1"}, 32'(launch1), 32'(0));
    chk({tag, "_busy0"},   32'(busy0),   32'(0));
    chk({tag, "_busy1"},   32'(busy1),   32'(0));
    chk({tag, "_done0"},   32'(done0),   32'(0));
    chk({tag, "_done1"},   32'(done1),   32'(0));
    chk({tag, "_sc0"},     32'(sc0),     32'(0));
    chk({tag, "_sc1"},     32'(sc1),     32'(0));
    chk({tag, "_ec0"},     32'(ec0),     32'(0));
    chk({tag, "_ec1"},     32'(ec1),     32'(0));
  endtask

  // mode: 0 all samples fast chain, 1 all slow, 2 random per sample.
  // A slow sample cannot reach the capture flop within one period, so it counts as an error.
  task automatic run(input int n, input int mode, input bit inject);
    int exp_done;
    int exp_err;
    bit slow[$];
    bit s;
    exp_done = n * COST + 1;
    exp_err  = 0;
    for (int k = 0; k < n; k++) begin
      s = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
      slow.push_back(s);
      if (s) exp_err++;
    end
    numSamples = CNT_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= exp_done + 2; c++) begin
      if ((c - 1) % COST == 0 && (c - 1) / COST < n)
        delay_ns = slow[(c - 1) / COST] ? int'($urandom_range(12, 19)) : int'($urandom_range(1, 8));
      start = inject && (c == 3 || c == exp_done);
      if (inject && c == 5) numSamples = CNT_W'(2);
      chk("done0", 32'(done0), 32'(c == exp_done));
      chk("done1", 32'(done1), 32'(c == exp_done));
      chk("busy0", 32'(busy0), 32'(c <= exp_done));
      tick();
    end
    start = 1'b0;
    lvl ^= n[0];
    chk("sample_count0", 32'(sc0), 32'(n));
    chk("sample_count1", 32'(sc1), 32'(n));
    chk("err_count0", 32'(ec0), 32'(exp_err));
    chk("err_count1", 32'(ec1), 32'(exp_err));
    chk("launch_level0", 32'(launch0), 32'(lvl));
    chk("launch_level1", 32'(launch1), 32'(lvl));
  endtask

  initial begin
    #2;
    chk_idle_zero("reset");
    tick();
    tick();
    rstN = 1'b1;
    tick();

    run(8, 0, 1'b0);
    run(8, 1, 1'b0);
    run(0, 0, 1'b0);
    run(8, 0, 1'b1);
    run(3, 0, 1'b0);
    for (int r = 0; r < 6; r++) run(int'($urandom_range(0, 12)), 2, 1'b0);

    numSamples = CNT_W'(5);
    delay_ns = 15;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2;
    rstN = 1'b0;
    #1;
    chk_idle_zero("midrun_reset");
    lvl = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("reset_done0", 32'(done0), 32'(0));
      chk("reset_busy0", 32'(busy0), 32'(0));
    end
    rstN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_reset_done0", 32'(done0), 32'(0));
      chk("post_reset_sc0", 32'(sc0), 32'(0));
    end
    run(5, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
